// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with byte/half/word lanes, wait-state stalls
// and first-misaligned-address capture.
module mem_stage #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Fault,
   output logic [31:0] BadAddr
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t r_state, w_next;
   logic [2:0] r_cnt, w_cnt_next;
   logic r_is_wr, r_faulted;
   logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] w_idx;
   logic w_req, w_mis, w_done, w_is_wr, w_unused;
   logic [31:0] w_word, w_mask, w_wdat, w_ext;
   logic [15:0] w_lane16;
   logic [7:0] w_lane8;
   assign w_idx = Address[ADDR_WIDTH+1:2];
   assign w_unused = ^Address[31:ADDR_WIDTH+2];
   assign w_req = MemRead | MemWrite;
   assign w_mis = (Size == 2'b01 && Address[0]) || (Size[1] && Address[1:0] != 2'b00);
   // the request kind is latched on acceptance; only data/address stay live
   assign w_is_wr = (r_state == IDLE) ? MemWrite : r_is_wr;
   always_comb begin
      w_next = r_state;
      w_cnt_next = r_cnt;
      Stall = 1'b0;
      Fault = 1'b0;
      w_done = 1'b0;
      if (!Reset) begin
         if (r_state == IDLE) begin
            if (w_req && w_mis) begin
               Fault = 1'b1;
            end else if (w_req) begin
               w_done = (WAIT_STATES == 0);
               Stall = (WAIT_STATES != 0);
               w_next = (WAIT_STATES != 0) ? BUSY : IDLE;
               w_cnt_next = (WAIT_STATES != 0) ? 3'(WAIT_STATES - 1) : 3'd0;
            end
         end else begin
            Stall = (r_cnt != 3'd0);
            w_done = (r_cnt == 3'd0);
            w_cnt_next = (r_cnt != 3'd0) ? r_cnt - 3'd1 : 3'd0;
            w_next = (r_cnt != 3'd0) ? BUSY : IDLE;
         end
      end
   end
   assign w_word = r_mem[w_idx];
   assign w_lane16 = Address[1] ? w_word[31:16] : w_word[15:0];
   assign w_lane8 = Address[0] ? w_lane16[15:8] : w_lane16[7:0];
   assign w_ext = (Size == 2'b00) ? {{24{w_lane8[7] & ~Unsigned}}, w_lane8} :
                  (Size == 2'b01) ? {{16{w_lane16[15] & ~Unsigned}}, w_lane16} : w_word;
   assign ReadData = (w_done && !w_is_wr) ? w_ext : 32'd0;
   assign w_mask = (Size == 2'b00) ? (32'h0000_00FF << {Address[1:0], 3'b000}) :
                   (Size == 2'b01) ? (32'h0000_FFFF << {Address[1], 4'b0000}) : 32'hFFFF_FFFF;
   assign w_wdat = (Size == 2'b00) ? {4{WriteData[7:0]}} :
                   (Size == 2'b01) ? {2{WriteData[15:0]}} : WriteData;
   always_ff @(posedge Clk) begin
      if (w_done && w_is_wr)
         r_mem[w_idx] <= (w_word & ~w_mask) | (w_wdat & w_mask);
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
         r_cnt <= 3'd0;
         r_is_wr <= 1'b0;
         r_faulted <= 1'b0;
         BadAddr <= 32'd0;
      end else begin
         r_state <= w_next;
         r_cnt <= w_cnt_next;
         if (r_state == IDLE)
            r_is_wr <= MemWrite;
         if (Fault && !r_faulted) begin
            r_faulted <= 1'b1;
            BadAddr <= Address;
         end
      end
   end
endmodule
